// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and defaults for the PLL reset/lock sequencer
//
// Purpose: state encoding and default parameter values for pll_rst_seq, plus
// a counter-width helper that never returns a zero-width result.
// Ports: none (package).

package pll_seq_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_seq_state_t;

    localparam int DEF_RST_HOLD_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT    = 50000;
    localparam int DEF_LOCK_STABLE     = 1024;
    localparam int DEF_MAX_RETRY       = 3;

    // A counter that only ever holds 0..n-1 needs $clog2(n) bits; n=1 still
    // needs one bit to exist.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer, async active-low reset to 0
//
// Purpose: brings an asynchronous level into the clk domain. Output lags the
// input by two clk edges.
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset (flops clear to 0)
//   d_i    in   asynchronous input level
//   q_o    out  synchronized level

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - reset and lock sequencer for the VGA pixel-clock PLL
//
// Purpose: holds the PLL in reset, waits for and qualifies lock, then releases
// the VGA-domain reset request. Retries on lock timeout, re-sequences on lock
// loss, restarts on a software relock request.
// Optional feature: define PLL_SEQ_RETRY_LIMIT_EN to enter FAIL after
// MAX_RETRY consecutive timeouts; otherwise retries continue forever and
// fail_o is constant 0.
// Ports:
//   clk          in   board clock (also the PLL reference)
//   resetn       in   asynchronous active-low reset
//   pll_lock_i   in   raw PLL lock, asynchronous
//   relock_i     in   single-cycle software restart request
//   pll_reset_o  out  PLL reset, active high
//   vga_rstn_o   out  active-low VGA-domain reset request
//   locked_o     out  high in RUN
//   fail_o       out  high in FAIL
//   retry_cnt_o  out  timeouts since last lock, saturating at 3

module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE     = DEF_LOCK_STABLE,
    parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock_i,
    input  logic       relock_i,
    output logic       pll_reset_o,
    output logic       vga_rstn_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o
);

    localparam int HOLD_W = cnt_width(RST_HOLD_CYCLES);
    localparam int STAB_W = cnt_width(LOCK_STABLE);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

`ifdef PLL_SEQ_RETRY_LIMIT_EN
    localparam bit RETRY_LIMIT_EN = 1'b1;
`else
    localparam bit RETRY_LIMIT_EN = 1'b0;
`endif

    pll_seq_state_t    state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        retry_q, retry_d;
    logic              pll_reset_q, pll_reset_d;
    logic              run_q, run_d;
    logic              fail_q, fail_d;
    logic              lock_s;
    logic              timeout;
    logic              limit_hit;
    logic [1:0]        retry_inc;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    assign timeout   = (tmo_q == TMO_LAST);
    assign retry_inc = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
    // Compared as int so a MAX_RETRY beyond the 2-bit counter range never aliases.
    assign limit_hit = RETRY_LIMIT_EN && (int'(retry_q) == MAX_RETRY - 1);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stab_d  = stab_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;

        if (relock_i) begin
            state_d = RST_HOLD;
            hold_d  = '0;
            stab_d  = '0;
            tmo_d   = '0;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                RST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        tmo_d   = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                WAIT_LOCK, STABLE: begin
                    // Timeout outranks any lock transition seen on the same edge.
                    if (timeout) begin
                        retry_d = retry_inc;
                        hold_d  = '0;
                        state_d = limit_hit ? FAIL : RST_HOLD;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                        if (state_q == WAIT_LOCK) begin
                            if (lock_s) begin
                                state_d = STABLE;
                                stab_d  = '0;
                            end
                        end else if (!lock_s) begin
                            state_d = WAIT_LOCK;
                        end else if (stab_q == STAB_LAST) begin
                            state_d = RUN;
                            retry_d = 2'd0;
                        end else begin
                            stab_d = stab_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = RST_HOLD;
                        hold_d  = '0;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RST_HOLD;
                    hold_d  = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they change on the entry edge.
        pll_reset_d = (state_d == RST_HOLD) || (state_d == FAIL);
        run_d       = (state_d == RUN);
        fail_d      = RETRY_LIMIT_EN && (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RST_HOLD;
            hold_q      <= '0;
            stab_q      <= '0;
            tmo_q       <= '0;
            retry_q     <= 2'd0;
            pll_reset_q <= 1'b1;
            run_q       <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            run_q       <= run_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign vga_rstn_o  = run_q;
    assign locked_o    = run_q;
    assign fail_o      = fail_q;
    assign retry_cnt_o = retry_q;

endmodule
